// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator/capture blocks.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } pwm_state_t;

    localparam int COUNT_SIZE_DEF = 16;

    function automatic logic [31:0] max_count(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus history flop; reports synchronized level and edges.
module pwm_sync_edge (
    input  logic sys_clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0] first sync stage, [1] synchronized level, [2] history
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM input and publishes each
// completed period as a coherent {period, high} pair with valid/overrun status.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int COUNT_SIZE = COUNT_SIZE_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  use_sys,
    input  logic                  clk_in,
    input  logic                  pwm_in,
    input  logic                  rd,
    output logic [COUNT_SIZE-1:0] period_out,
    output logic [COUNT_SIZE-1:0] high_out,
    output logic                  sample_valid,
    output logic                  overrun,
    output logic                  stuck_high,
    output logic                  stuck_low
);

    localparam logic [COUNT_SIZE-1:0] MAX = COUNT_SIZE'(max_count(COUNT_SIZE));

    pwm_state_t            state_q, state_d;
    logic [COUNT_SIZE-1:0] cnt_q, cnt_d, hi_lat_q, hi_lat_d;
    logic [COUNT_SIZE-1:0] period_q, period_d, high_q, high_d;
    logic                  valid_q, valid_d, overrun_q, overrun_d;
    logic                  stuck_high_q, stuck_high_d, stuck_low_q, stuck_low_d;
    logic                  rd_q, rd_d;

    logic                  lvl, rise, fall, tick, rd_edge, publish;
    logic [COUNT_SIZE-1:0] cnt_inc;

    pwm_sync_edge u_sync (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .async_in (pwm_in),
        .level    (lvl),
        .rise     (rise),
        .fall     (fall)
    );

    assign tick    = use_sys | clk_in;
    assign rd_edge = rd & ~rd_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_lat_d     = hi_lat_q;
        period_d     = period_q;
        high_d       = high_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;
        rd_d         = rd;
        publish      = 1'b0;
        cnt_inc      = (cnt_q == MAX) ? MAX : cnt_q + COUNT_SIZE'(tick);

        if (!ena) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hi_lat_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM, MEAS: begin
                    if (rise) begin
                        if (state_q == MEAS) begin
                            period_d = cnt_q;
                            high_d   = hi_lat_q;
                            publish  = 1'b1;
                        end
                        state_d      = MEAS;
                        cnt_d        = COUNT_SIZE'(tick);
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                    end else if (cnt_q == MAX && !fall) begin
                        // Input has not moved for a full counter span.
                        period_d     = MAX;
                        high_d       = lvl ? MAX : '0;
                        stuck_high_d = stuck_high_q | lvl;
                        stuck_low_d  = stuck_low_q | ~lvl;
                        publish      = 1'b1;
                        state_d      = ARM;
                        cnt_d        = '0;
                    end else begin
                        if (fall && state_q == MEAS) begin
                            hi_lat_d = cnt_q;
                        end
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A read landing on the publish cycle acknowledges the old sample only.
        if (publish) begin
            valid_d   = 1'b1;
            overrun_d = rd_edge ? 1'b0 : (valid_q | overrun_q);
        end else if (rd_edge) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_lat_q     <= '0;
            period_q     <= '0;
            high_q       <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
            rd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_lat_q     <= hi_lat_d;
            period_q     <= period_d;
            high_q       <= high_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
            rd_q         <= rd_d;
        end
    end

    assign period_out   = period_q;
    assign high_out     = high_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign stuck_high   = stuck_high_q;
    assign stuck_low    = stuck_low_q;

endmodule
